// File: rtl/koa_mult_ctrl_if.sv
// Bus bundle between the two requesters, the consumer, the shared Karatsuba
// multiplier and the koa_mult_ctrl arbiter/sequencer.
interface koa_mult_ctrl_if #(
  parameter int SW = 24
);
  logic              req0_i;
  logic [SW-1:0]     a0_i;
  logic [SW-1:0]     b0_i;
  logic              req1_i;
  logic [SW-1:0]     a1_i;
  logic [SW-1:0]     b1_i;
  logic [1:0]        gnt_o;
  logic              busy_o;
  logic [SW-1:0]     mul_a_o;
  logic [SW-1:0]     mul_b_o;
  logic              mul_load_o;
  logic [2*SW-1:0]   mul_result_i;
  logic [2*SW-1:0]   result_o;
  logic              owner_o;
  logic              valid_o;
  logic              ready_i;

  modport slave (
    input  req0_i, a0_i, b0_i, req1_i, a1_i, b1_i, mul_result_i, ready_i,
    output gnt_o, busy_o, mul_a_o, mul_b_o, mul_load_o, result_o, owner_o, valid_o
  );

  modport master (
    output req0_i, a0_i, b0_i, req1_i, a1_i, b1_i, mul_result_i, ready_i,
    input  gnt_o, busy_o, mul_a_o, mul_b_o, mul_load_o, result_o, owner_o, valid_o
  );
endinterface

// File: rtl/koa_mult_ctrl.sv
// Round-robin front end for a shared Karatsuba multiplier: grants one of two
// requesters, waits LAT cycles for the product, and holds it until accepted.
module koa_mult_ctrl #(
  parameter int SW  = 24,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  koa_mult_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, CAPT, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            own_q, own_d;
  logic            owner_q, owner_d;
  logic [SW-1:0]   a_q, a_d;
  logic [SW-1:0]   b_q, b_d;
  logic [2*SW-1:0] res_q, res_d;
  logic            win;
  logic [1:0]      gnt;
  logic            mul_load;

  // On contention the requester not served last wins; a lone request wins outright.
  assign win = (bus.req0_i && bus.req1_i) ? ~last_q : bus.req1_i;

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    own_d    = own_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    gnt      = 2'b00;
    mul_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0_i || bus.req1_i) begin
          gnt[win] = 1'b1;
          last_d   = win;
          own_d    = win;
          a_d      = win ? bus.a1_i : bus.a0_i;
          b_d      = win ? bus.b1_i : bus.b0_i;
          cnt_d    = 4'(LAT);
          state_d  = CALC;
        end
      end
      CALC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          mul_load = 1'b1;
          state_d  = CAPT;
        end
      end
      CAPT: begin
        res_d   = bus.mul_result_i;
        owner_d = own_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Grant is combinational from IDLE, so it is masked while reset is held.
  assign bus.gnt_o      = rst ? 2'b00 : gnt;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.mul_a_o    = a_q;
  assign bus.mul_b_o    = b_q;
  assign bus.mul_load_o = mul_load;
  assign bus.result_o   = res_q;
  assign bus.owner_o    = owner_q;
  assign bus.valid_o    = (state_q == DONE);

endmodule

// File: tb/tb_koa_mult_ctrl.sv
// Directed bench for koa_mult_ctrl: a vector table of single operations plus
// hand-written contention, backpressure and mid-operation reset sequences.
module tb_koa_mult_ctrl;
  localparam int SW  = 24;
  localparam int LAT = 2;

  logic clk;
  logic rst;
  logic [2*SW-1:0] mult_q;

  int n_checks = 0;
  int n_fail   = 0;

  koa_mult_ctrl_if #(.SW(SW)) bus ();

  koa_mult_ctrl #(.SW(SW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier stand-in: result register loads on the load strobe.
  always_ff @(posedge clk) begin
    if (bus.mul_load_o) mult_q <= (2*SW)'(bus.mul_a_o) * (2*SW)'(bus.mul_b_o);
  end
  assign bus.mul_result_i = mult_q;

  typedef struct {
    logic          r0;
    logic          r1;
    logic [SW-1:0] a0;
    logic [SW-1:0] b0;
    logic [SW-1:0] a1;
    logic [SW-1:0] b1;
    logic [1:0]    gnt;
    logic          owner;
    logic [2*SW-1:0] prod;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    logic [SW-1:0] ea;
    t  = $sformatf("vec%0d", idx);
    ea = (v.gnt == 2'b10) ? v.a1 : v.a0;
    bus.req0_i = v.r0;
    bus.req1_i = v.r1;
    bus.a0_i = v.a0; bus.b0_i = v.b0;
    bus.a1_i = v.a1; bus.b1_i = v.b1;
    #1 check({t, "_gnt"}, 64'(bus.gnt_o), 64'(v.gnt));
    tick();
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      #1 check($sformatf("%s_load_c%0d", t, c), 64'(bus.mul_load_o), 64'(c == LAT));
      tick();
    end
    #1;
    check({t, "_valid"},  64'(bus.valid_o),  64'd1);
    check({t, "_result"}, 64'(bus.result_o), 64'(v.prod));
    check({t, "_owner"},  64'(bus.owner_o),  64'(v.owner));
    check({t, "_mul_a"},  64'(bus.mul_a_o),  64'(ea));
    tick();
    #1 check({t, "_idle"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_cyc[$];
    logic [1:0] g_val[$];
    int n_load;
    logic saw_valid;

    // Pointer starts at 1 after reset, so the first contention goes to requester 0.
    vecs[0] = '{1'b1, 1'b0, 24'h000003, 24'h000005, 24'h0, 24'h0, 2'b01, 1'b0, 48'h00000000000F};
    vecs[1] = '{1'b1, 1'b1, 24'h000010, 24'h000010, 24'h000007, 24'h000009, 2'b10, 1'b1, 48'h00000000003F};
    vecs[2] = '{1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'h000002, 24'h000003, 2'b01, 1'b0, 48'hFFFFFE000001};
    vecs[3] = '{1'b0, 1'b1, 24'h0, 24'h0, 24'h123456, 24'h000100, 2'b10, 1'b1, 48'h000012345600};
    vecs[4] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000001, 24'h0, 24'h0, 2'b01, 1'b0, 48'h000000FFFFFF};
    vecs[5] = '{1'b1, 1'b0, 24'h800000, 24'h000002, 24'h0, 24'h0, 2'b01, 1'b0, 48'h000001000000};
    vecs[6] = '{1'b0, 1'b1, 24'h0, 24'h0, 24'h000000, 24'hABCDEF, 2'b10, 1'b1, 48'h000000000000};
    vecs[7] = '{1'b1, 1'b1, 24'h001000, 24'h001000, 24'h000005, 24'h000005, 2'b01, 1'b0, 48'h000001000000};

    rst = 1'b1;
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    bus.a0_i = '0; bus.b0_i = '0; bus.a1_i = '0; bus.b1_i = '0;
    bus.ready_i = 1'b1;
    #2;
    check("rst_gnt",    64'(bus.gnt_o),      64'd0);
    check("rst_busy",   64'(bus.busy_o),     64'd0);
    check("rst_load",   64'(bus.mul_load_o), 64'd0);
    check("rst_valid",  64'(bus.valid_o),    64'd0);
    check("rst_result", 64'(bus.result_o),   64'd0);
    check("rst_owner",  64'(bus.owner_o),    64'd0);
    check("rst_mul_a",  64'(bus.mul_a_o),    64'd0);
    check("rst_mul_b",  64'(bus.mul_b_o),    64'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Both requests rise one cycle after reset: requester 0 first, then 1.
    do_reset();
    tick();
    bus.req0_i = 1'b1; bus.a0_i = 24'd2; bus.b0_i = 24'd3;
    bus.req1_i = 1'b1; bus.a1_i = 24'd4; bus.b1_i = 24'd5;
    #1 check("cont_gnt0", 64'(bus.gnt_o), 64'b01);
    tick();
    bus.req0_i = 1'b0;
    tick(); tick(); tick();
    #1;
    check("cont_owner0", 64'(bus.owner_o),  64'd0);
    check("cont_res0",   64'(bus.result_o), 64'd6);
    tick();
    #1 check("cont_gnt1", 64'(bus.gnt_o), 64'b10);
    tick();
    bus.req1_i = 1'b0;
    tick(); tick(); tick();
    #1;
    check("cont_owner1", 64'(bus.owner_o),  64'd1);
    check("cont_res1",   64'(bus.result_o), 64'd20);
    tick();

    // Sustained contention: grants alternate with LAT+3 spacing.
    do_reset();
    bus.req0_i = 1'b1; bus.req1_i = 1'b1;
    n_load = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      #1;
      if (bus.gnt_o != 2'b00) begin
        g_cyc.push_back(cyc);
        g_val.push_back(bus.gnt_o);
      end
      if (bus.mul_load_o) n_load++;
      tick();
    end
    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
    check("sust_ngrants", 64'(g_cyc.size()), 64'd5);
    check("sust_nloads",  64'(n_load),       64'd5);
    for (int i = 0; i < 4 && i < g_cyc.size(); i++) begin
      check($sformatf("sust_gnt%0d", i), 64'(g_val[i]), (i % 2 == 0) ? 64'b01 : 64'b10);
      if (i > 0)
        check($sformatf("sust_space%0d", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'(LAT + 3));
    end
    tick(); tick(); tick(); tick();

    // Backpressure in DONE with a request pending from requester 1.
    do_reset();
    bus.ready_i = 1'b0;
    bus.req0_i = 1'b1; bus.a0_i = 24'h000123; bus.b0_i = 24'h000010;
    #1 check("bp_gnt", 64'(bus.gnt_o), 64'b01);
    tick();
    bus.req0_i = 1'b0;
    bus.req1_i = 1'b1; bus.a1_i = 24'd2; bus.b1_i = 24'd2;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_valid%0d", k),  64'(bus.valid_o),    64'd1);
      check($sformatf("bp_result%0d", k), 64'(bus.result_o),   64'h1230);
      check($sformatf("bp_gnt%0d", k),    64'(bus.gnt_o),      64'd0);
      check($sformatf("bp_load%0d", k),   64'(bus.mul_load_o), 64'd0);
      tick();
    end
    bus.ready_i = 1'b1;
    tick();
    #1 check("bp_pending_gnt", 64'(bus.gnt_o), 64'b10);
    tick();
    bus.req1_i = 1'b0;
    tick(); tick(); tick();
    #1;
    check("bp_owner1", 64'(bus.owner_o),  64'd1);
    check("bp_res1",   64'(bus.result_o), 64'd4);
    tick();

    // Reset pulsed in CALC with a stale result and owner still registered.
    bus.req0_i = 1'b1; bus.a0_i = 24'd7; bus.b0_i = 24'd7;
    #1 check("mr_gnt", 64'(bus.gnt_o), 64'b01);
    tick();
    bus.req0_i = 1'b0;
    #1 check("mr_busy_pre", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("mr_busy",   64'(bus.busy_o),     64'd0);
    check("mr_load",   64'(bus.mul_load_o), 64'd0);
    check("mr_valid",  64'(bus.valid_o),    64'd0);
    check("mr_result", 64'(bus.result_o),   64'd0);
    check("mr_owner",  64'(bus.owner_o),    64'd0);
    check("mr_mul_a",  64'(bus.mul_a_o),    64'd0);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 if (bus.valid_o || bus.busy_o) saw_valid = 1'b1;
      tick();
    end
    check("mr_no_valid", 64'(saw_valid), 64'd0);
    bus.req1_i = 1'b1; bus.a1_i = 24'd9; bus.b1_i = 24'd11;
    #1 check("mr_gnt1", 64'(bus.gnt_o), 64'b10);
    tick();
    bus.req1_i = 1'b0;
    tick(); tick(); tick();
    #1;
    check("mr_res1",   64'(bus.result_o), 64'd99);
    check("mr_owner1", 64'(bus.owner_o),  64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
